pkslot_tracker: RTL and testbench

Parametrised packet-type decoder and multi-slot TX/RX window sequencer for the link controller; next generation of the per-connection type decoder. Decodes the 4-bit packet type into payload length and coding attributes, latches the decode at first-slot encode time so it is stable for the whole packet, and drives TX/RX slot-extension windows, end-of-slot pulses and the correlator mask. Unlike the previous generation, RX window length follows the received packet type, not the transmitted one.

---
 rtl/pkslot_tracker.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pkslot_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkslot_tracker.sv
// rtl/pkslot_tracker.sv - packet-type decoder and multi-slot TX/RX window sequencer
// Optional feature macro: PKSLOT_RXTYPE_EN (RX window length from received packet type)
module pkslot_tracker #(
    parameter int LENW      = 10,
    parameter int SLOTCNTW  = 3,
    parameter int MAX_SLOTS = 5
) (
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                ms_tslot_p,
    input  logic                ms_halftslot_p,
    input  logic                is_BRmode,
    input  logic                is_eSCO,
    input  logic                is_SCO,
    input  logic [3:0]          tx_pk_type,
    input  logic [3:0]          rx_pk_type,
    input  logic                rx_pk_type_valid,
    input  logic [LENW-1:0]     regi_payloadlen,
    input  logic                pktype_data,
    input  logic                conns_tx1stslot,
    input  logic                pk_encode_1stslot,
    output logic [LENW+2:0]     pylenbit_f,
    output logic [SLOTCNTW-1:0] tx_slots_f,
    output logic [SLOTCNTW-1:0] rx_slots_f,
    output logic                fec31encode_f,
    output logic                fec32encode_f,
    output logic                crcencode_f,
    output logic                packet_BRmode_f,
    output logic                packet_DPSK_f,
    output logic                BRss_f,
    output logic                existpyheader_f,
    output logic                allowedeSCOtype,
    output logic                txextendslot,
    output logic                rxextendslot,
    output logic                mask_corre_win,
    output logic                conns_rx1stslot,
    output logic                ms_TXslot_endp,
    output logic                ms_RXslot_endp,
    output logic [SLOTCNTW-1:0] tx_slot_idx,
    output logic [SLOTCNTW-1:0] rx_slot_idx
);

    localparam int PW = LENW + 3;
    localparam logic [SLOTCNTW-1:0] ONE = SLOTCNTW'(1);
    localparam logic [SLOTCNTW-1:0] TWO = SLOTCNTW'(2);

    // Slot count implied by a packet type, clamped to the largest honoured count.
    function automatic logic [SLOTCNTW-1:0] slots_of(input logic [3:0] t);
        int n;
        case (t)
            4'hA, 4'hB, 4'hC, 4'hD: n = 3;
            4'hE, 4'hF:             n = 5;
            default:                n = 1;
        endcase
        if (n > MAX_SLOTS) n = MAX_SLOTS;
        return SLOTCNTW'(n);
    endfunction

    logic [PW-1:0]       base_len, sco_len;
    logic [PW-1:0]       d_len;
    logic                d_hdr, d_fec31, d_fec32, d_crc, d_br, d_dpsk;
    logic [SLOTCNTW-1:0] d_slots;

    logic [PW-1:0]       pylen_q;
    logic                hdr_q, fec31_q, fec32_q, crc_q, br_q, dpsk_q;
    logic [SLOTCNTW-1:0] txslots_q;

    logic                txext_q, txext_d, rxext_q, rxext_d;
    logic [SLOTCNTW-1:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic                rx1st_q, rx1st_d, mask_q, mask_d;
    logic                tx_last, rx_last;
    logic [SLOTCNTW-1:0] rx_eff;

    assign base_len = ({3'b000, regi_payloadlen} + PW'(pktype_data)) << 3;
    assign sco_len  = PW'(80) + (({3'b000, regi_payloadlen} + PW'(1)) << 3);

    // Attribute decode of the type about to be transmitted.
    always_comb begin
        d_hdr   = 1'b1;
        d_fec31 = 1'b0;
        d_fec32 = 1'b1;
        d_crc   = 1'b1;
        d_br    = 1'b1;
        d_dpsk  = 1'b1;
        d_len   = base_len;
        d_slots = slots_of(tx_pk_type);
        case (tx_pk_type)
            4'h0, 4'h1: d_len = '0;
            4'h2:       d_len = PW'(144);
            4'h4: begin
                d_fec32 = 1'b0;
                d_br    = is_BRmode;
            end
            4'h5: begin
                d_len   = PW'(80);
                d_fec31 = 1'b1;
                d_crc   = 1'b0;
                d_hdr   = 1'b0;
            end
            4'h6: begin
                d_hdr = 1'b0;
                if (is_eSCO) begin
                    d_br    = 1'b0;
                    d_fec32 = 1'b0;
                end else begin
                    d_len = PW'(160);
                    d_crc = 1'b0;
                end
            end
            4'h7: begin
                d_hdr = 1'b0;
                if (is_eSCO && is_BRmode) begin
                    d_fec32 = 1'b0;
                end else if (is_eSCO) begin
                    d_crc  = 1'b0;
                    d_br   = 1'b0;
                    d_dpsk = 1'b0;
                end else begin
                    d_fec32 = 1'b0;
                    d_crc   = 1'b0;
                    d_len   = PW'(240);
                end
            end
            4'h8: begin
                if (is_SCO) begin
                    d_len = sco_len;
                end else begin
                    d_br    = 1'b0;
                    d_dpsk  = 1'b0;
                    d_fec32 = 1'b0;
                end
            end
            4'h9: d_crc = 1'b0;
            4'hA, 4'hB, 4'hE, 4'hF: begin
                d_br = is_BRmode;
                if (tx_pk_type[0]) d_dpsk = is_BRmode;
            end
            4'hC, 4'hD: begin
                d_hdr = 1'b0;
                if (tx_pk_type[0]) d_dpsk = is_BRmode;
            end
            default: ;
        endcase
    end

    // Freeze the TX decode at first-slot encode so it holds for the whole packet.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            pylen_q   <= '0;
            hdr_q     <= 1'b0;
            fec31_q   <= 1'b0;
            fec32_q   <= 1'b0;
            crc_q     <= 1'b0;
            br_q      <= 1'b0;
            dpsk_q    <= 1'b0;
            txslots_q <= ONE;
        end else if (pk_encode_1stslot) begin
            pylen_q   <= d_len;
            hdr_q     <= d_hdr;
            fec31_q   <= d_fec31;
            fec32_q   <= d_fec32;
            crc_q     <= d_crc;
            br_q      <= d_br;
            dpsk_q    <= d_dpsk;
            txslots_q <= d_slots;
        end
    end

`ifdef PKSLOT_RXTYPE_EN
    logic                rx_load;
    logic [SLOTCNTW-1:0] rxslots_q, rxslots_d, rx_dec;

    assign rx_load = rx_pk_type_valid & rx1st_q;
    assign rx_dec  = slots_of(rx_pk_type);
    // A header arriving on the closing strobe already decides that slot.
    assign rx_eff  = rx_load ? rx_dec : rxslots_q;

    // RX length: back to one slot when TX ends, then follow the received header.
    always_comb begin
        rxslots_d = rxslots_q;
        if (ms_TXslot_endp)  rxslots_d = ONE;
        else if (rx_load)    rxslots_d = rx_dec;
    end

    // RX slot-count register.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) rxslots_q <= ONE;
        else       rxslots_q <= rxslots_d;
    end

    assign rx_slots_f = rxslots_q;
`else
    logic unused_rx;
    assign unused_rx  = ^{rx_pk_type, rx_pk_type_valid};
    assign rx_eff     = txslots_q;
    assign rx_slots_f = txslots_q;
`endif

    assign tx_last = txext_q & (tx_idx_q >= txslots_q);
    assign rx_last = rxext_q & (rx_idx_q >= rx_eff);

    // A first-slot strobe always wins, so an aborted window never emits an end pulse.
    assign ms_TXslot_endp = ms_tslot_p & (conns_tx1stslot ? (txslots_q <= ONE) : tx_last);
    assign ms_RXslot_endp = ms_tslot_p & (rx1st_q ? (rx_eff <= ONE) : rx_last);

    // Window sequencing for both directions plus the correlator mask.
    always_comb begin
        txext_d  = txext_q;
        tx_idx_d = tx_idx_q;
        rxext_d  = rxext_q;
        rx_idx_d = rx_idx_q;
        rx1st_d  = rx1st_q;
        mask_d   = mask_q;
        if (ms_tslot_p && conns_tx1stslot) begin
            txext_d  = (txslots_q > ONE);
            tx_idx_d = (txslots_q > ONE) ? TWO : ONE;
        end else if (ms_tslot_p && txext_q) begin
            txext_d  = !tx_last;
            tx_idx_d = tx_last ? ONE : tx_idx_q + ONE;
        end
        if (ms_tslot_p && rx1st_q) begin
            rxext_d  = (rx_eff > ONE);
            rx_idx_d = (rx_eff > ONE) ? TWO : ONE;
        end else if (ms_tslot_p && rxext_q) begin
            rxext_d  = !rx_last;
            rx_idx_d = rx_last ? ONE : rx_idx_q + ONE;
        end
        if (ms_TXslot_endp)  rx1st_d = 1'b1;
        else if (ms_tslot_p) rx1st_d = 1'b0;
        if (ms_halftslot_p && conns_tx1stslot && (txslots_q > ONE)) mask_d = 1'b1;
        else if (ms_halftslot_p && tx_last)                         mask_d = 1'b0;
    end

    // Window state registers.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            txext_q  <= 1'b0;
            tx_idx_q <= ONE;
            rxext_q  <= 1'b0;
            rx_idx_q <= ONE;
            rx1st_q  <= 1'b0;
            mask_q   <= 1'b0;
        end else begin
            txext_q  <= txext_d;
            tx_idx_q <= tx_idx_d;
            rxext_q  <= rxext_d;
            rx_idx_q <= rx_idx_d;
            rx1st_q  <= rx1st_d;
            mask_q   <= mask_d;
        end
    end

    assign pylenbit_f      = pylen_q;
    assign tx_slots_f      = txslots_q;
    assign fec31encode_f   = fec31_q;
    assign fec32encode_f   = fec32_q;
    assign crcencode_f     = crc_q;
    assign packet_BRmode_f = br_q;
    assign packet_DPSK_f   = dpsk_q;
    assign existpyheader_f = hdr_q;
    assign BRss_f          = br_q & (txslots_q == ONE);
    assign allowedeSCOtype = tx_pk_type inside {4'h0, 4'h1, 4'h6, 4'h7, 4'hC, 4'hD};
    assign txextendslot    = txext_q;
    assign rxextendslot    = rxext_q;
    assign mask_corre_win  = mask_q;
    assign conns_rx1stslot = rx1st_q;
    assign tx_slot_idx     = tx_idx_q;
    assign rx_slot_idx     = rx_idx_q;

endmodule

// File: tb/tb_pkslot_tracker.sv
// tb/tb_pkslot_tracker.sv - scoreboard bench for pkslot_tracker
module tb_pkslot_tracker;

`ifdef PKSLOT_RXTYPE_EN
    localparam bit RXT = 1'b1;
`else
    localparam bit RXT = 1'b0;
`endif

    logic        clk_6M = 1'b0;
    logic        rstz, ms_tslot_p, ms_halftslot_p, is_BRmode, is_eSCO, is_SCO;
    logic [3:0]  tx_pk_type, rx_pk_type;
    logic        rx_pk_type_valid, pktype_data, conns_tx1stslot, pk_encode_1stslot;
    logic [9:0]  regi_payloadlen;
    logic [12:0] pylenbit_f, u2_pylenbit_f;
    logic [2:0]  tx_slots_f, rx_slots_f, tx_slot_idx, rx_slot_idx;
    logic [2:0]  u2_tx_slots_f, u2_rx_slots_f, u2_tx_slot_idx, u2_rx_slot_idx;
    logic        fec31encode_f, fec32encode_f, crcencode_f, packet_BRmode_f, packet_DPSK_f;
    logic        BRss_f, existpyheader_f, allowedeSCOtype, txextendslot, rxextendslot;
    logic        mask_corre_win, conns_rx1stslot, ms_TXslot_endp, ms_RXslot_endp;
    logic        u2_fec31, u2_fec32, u2_crc, u2_br, u2_dpsk, u2_brss, u2_hdr, u2_esco;
    logic        u2_txext, u2_rxext, u2_mask, u2_rx1st, u2_txendp, u2_rxendp;

    int checks = 0;
    int errors = 0;
    int strobe_n = 0;
    int u2_tx_at = -1;
    int mon_e;
    int b;
    int tx_q[$];
    int rx_q[$];

    always #5 clk_6M = ~clk_6M;

    pkslot_tracker dut (
        .clk_6M(clk_6M), .rstz(rstz), .ms_tslot_p(ms_tslot_p), .ms_halftslot_p(ms_halftslot_p),
        .is_BRmode(is_BRmode), .is_eSCO(is_eSCO), .is_SCO(is_SCO), .tx_pk_type(tx_pk_type),
        .rx_pk_type(rx_pk_type), .rx_pk_type_valid(rx_pk_type_valid),
        .regi_payloadlen(regi_payloadlen), .pktype_data(pktype_data),
        .conns_tx1stslot(conns_tx1stslot), .pk_encode_1stslot(pk_encode_1stslot),
        .pylenbit_f(pylenbit_f), .tx_slots_f(tx_slots_f), .rx_slots_f(rx_slots_f),
        .fec31encode_f(fec31encode_f), .fec32encode_f(fec32encode_f), .crcencode_f(crcencode_f),
        .packet_BRmode_f(packet_BRmode_f), .packet_DPSK_f(packet_DPSK_f), .BRss_f(BRss_f),
        .existpyheader_f(existpyheader_f), .allowedeSCOtype(allowedeSCOtype),
        .txextendslot(txextendslot), .rxextendslot(rxextendslot), .mask_corre_win(mask_corre_win),
        .conns_rx1stslot(conns_rx1stslot), .ms_TXslot_endp(ms_TXslot_endp),
        .ms_RXslot_endp(ms_RXslot_endp), .tx_slot_idx(tx_slot_idx), .rx_slot_idx(rx_slot_idx)
    );

    pkslot_tracker #(.MAX_SLOTS(3)) u2 (
        .clk_6M(clk_6M), .rstz(rstz), .ms_tslot_p(ms_tslot_p), .ms_halftslot_p(ms_halftslot_p),
        .is_BRmode(is_BRmode), .is_eSCO(is_eSCO), .is_SCO(is_SCO), .tx_pk_type(tx_pk_type),
        .rx_pk_type(rx_pk_type), .rx_pk_type_valid(rx_pk_type_valid),
        .regi_payloadlen(regi_payloadlen), .pktype_data(pktype_data),
        .conns_tx1stslot(conns_tx1stslot), .pk_encode_1stslot(pk_encode_1stslot),
        .pylenbit_f(u2_pylenbit_f), .tx_slots_f(u2_tx_slots_f), .rx_slots_f(u2_rx_slots_f),
        .fec31encode_f(u2_fec31), .fec32encode_f(u2_fec32), .crcencode_f(u2_crc),
        .packet_BRmode_f(u2_br), .packet_DPSK_f(u2_dpsk), .BRss_f(u2_brss),
        .existpyheader_f(u2_hdr), .allowedeSCOtype(u2_esco),
        .txextendslot(u2_txext), .rxextendslot(u2_rxext), .mask_corre_win(u2_mask),
        .conns_rx1stslot(u2_rx1st), .ms_TXslot_endp(u2_txendp),
        .ms_RXslot_endp(u2_rxendp), .tx_slot_idx(u2_tx_slot_idx), .rx_slot_idx(u2_rx_slot_idx)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every end pulse pops the expected strobe number for its direction.
    always @(negedge clk_6M) begin
        if (rstz) begin
            if (ms_TXslot_endp) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_endp: pulse at strobe %0d, expected none", strobe_n);
                end else begin
                    mon_e = tx_q.pop_front();
                    if (mon_e != strobe_n) begin
                        errors++;
                        $display("FAIL tx_endp: pulse at strobe %0d expected %0d", strobe_n, mon_e);
                    end
                end
            end
            if (ms_RXslot_endp) begin
                checks++;
                if (rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_endp: pulse at strobe %0d, expected none", strobe_n);
                end else begin
                    mon_e = rx_q.pop_front();
                    if (mon_e != strobe_n) begin
                        errors++;
                        $display("FAIL rx_endp: pulse at strobe %0d expected %0d", strobe_n, mon_e);
                    end
                end
            end
            if (u2_txendp) u2_tx_at = strobe_n;
        end
    end

    task automatic latch(input logic [3:0] t);
        tx_pk_type        = t;
        pk_encode_1stslot = 1'b1;
        @(posedge clk_6M); #1;
        pk_encode_1stslot = 1'b0;
    endtask

    // One 8-cycle slot: half-slot strobe at cycle 3, slot strobe at cycle 7.
    task automatic slot(input logic first, input logic rxv, input logic [3:0] rxt, input int exp_mask);
        for (int c = 0; c < 8; c++) begin
            if (c == 5 && exp_mask >= 0) check("mask_corre_win", int'(mask_corre_win), exp_mask);
            conns_tx1stslot  = first;
            ms_halftslot_p   = (c == 3);
            ms_tslot_p       = (c == 7);
            rx_pk_type_valid = rxv && (c == 7);
            rx_pk_type       = rxt;
            if (c == 7) strobe_n++;
            @(posedge clk_6M); #1;
        end
        conns_tx1stslot  = 1'b0;
        ms_halftslot_p   = 1'b0;
        ms_tslot_p       = 1'b0;
        rx_pk_type_valid = 1'b0;
    endtask

    initial begin
        rstz = 1'b0; ms_tslot_p = 1'b0; ms_halftslot_p = 1'b0;
        is_BRmode = 1'b1; is_eSCO = 1'b0; is_SCO = 1'b0;
        tx_pk_type = 4'h0; rx_pk_type = 4'h0; rx_pk_type_valid = 1'b0;
        regi_payloadlen = 10'd0; pktype_data = 1'b0;
        conns_tx1stslot = 1'b0; pk_encode_1stslot = 1'b0;
        repeat (3) @(posedge clk_6M); #1;
        check("rst pylenbit", int'(pylenbit_f), 0);
        check("rst tx_slots", int'(tx_slots_f), 1);
        check("rst rx_slots", int'(rx_slots_f), 1);
        check("rst tx_idx", int'(tx_slot_idx), 1);
        check("rst rx_idx", int'(rx_slot_idx), 1);
        check("rst flags", int'({txextendslot, rxextendslot, mask_corre_win, conns_rx1stslot}), 0);
        check("rst attrs", int'({fec31encode_f, fec32encode_f, crcencode_f, packet_BRmode_f,
                                 packet_DPSK_f, BRss_f, existpyheader_f}), 0);
        rstz = 1'b1;
        @(posedge clk_6M); #1;

        // 5-slot DH5-style packet
        regi_payloadlen = 10'd339;
        latch(4'hF);
        check("F pylenbit", int'(pylenbit_f), 2712);
        check("F tx_slots", int'(tx_slots_f), 5);
        check("F attrs", int'({fec31encode_f, fec32encode_f, crcencode_f, packet_BRmode_f,
                               packet_DPSK_f, BRss_f, existpyheader_f}), 7'b0111101);
        check("F allowedeSCO", int'(allowedeSCOtype), 0);
        b = strobe_n;
        tx_q.push_back(b + 5);
        rx_q.push_back(RXT ? b + 6 : b + 10);
        slot(1'b1, 1'b0, 4'h0, 1);
        check("F idx after s1", int'(tx_slot_idx), 2);
        check("F ext after s1", int'(txextendslot), 1);
        repeat (3) slot(1'b0, 1'b0, 4'h0, 1);
        check("F idx after s4", int'(tx_slot_idx), 5);
        slot(1'b0, 1'b0, 4'h0, 0);
        check("F ext after end", int'(txextendslot), 0);
        check("F rx1st after end", int'(conns_rx1stslot), 1);
        repeat (5) slot(1'b0, 1'b0, 4'h0, 0);

        // one-slot TX, received 3-slot header
        regi_payloadlen = 10'd17;
        latch(4'h3);
        check("3 BRss", int'(BRss_f), 1);
        b = strobe_n;
        tx_q.push_back(b + 1);
        rx_q.push_back(RXT ? b + 4 : b + 2);
        slot(1'b1, 1'b0, 4'h0, 0);
        slot(1'b0, 1'b1, 4'hB, 0);
        check("B rx_slots", int'(rx_slots_f), RXT ? 3 : 1);
        check("B rxext", int'(rxextendslot), int'(RXT));
        repeat (2) slot(1'b0, 1'b0, 4'h0, 0);

        // SCO length and latch stability
        is_SCO = 1'b1; regi_payloadlen = 10'd9;
        latch(4'h8);
        check("8 SCO pylenbit", int'(pylenbit_f), 160);
        check("8 SCO fec32", int'(fec32encode_f), 1);
        tx_pk_type = 4'h5; regi_payloadlen = 10'd100; is_SCO = 1'b0;
        repeat (2) @(posedge clk_6M); #1;
        check("8 held pylenbit", int'(pylenbit_f), 160);
        check("8 held slots", int'(tx_slots_f), 1);
        check("eSCO type 5", int'(allowedeSCOtype), 0);
        tx_pk_type = 4'hC; #1;
        check("eSCO type C", int'(allowedeSCOtype), 1);
        regi_payloadlen = 10'd9; pktype_data = 1'b1; is_BRmode = 1'b0;
        latch(4'h4);
        check("4 pylenbit", int'(pylenbit_f), 80);
        check("4 fec32/BR/BRss", int'({fec32encode_f, packet_BRmode_f, BRss_f}), 0);
        latch(4'h2);
        check("2 pylenbit", int'(pylenbit_f), 144);
        latch(4'h5);
        check("5 pylenbit", int'(pylenbit_f), 80);
        check("5 fec31/crc/hdr", int'({fec31encode_f, crcencode_f, existpyheader_f}), 3'b100);
        latch(4'h7);
        check("7 pylenbit", int'(pylenbit_f), 240);
        check("7 fec32/crc/hdr", int'({fec32encode_f, crcencode_f, existpyheader_f}), 0);
        is_eSCO = 1'b1; pktype_data = 1'b0;
        latch(4'h6);
        check("6 eSCO pylenbit", int'(pylenbit_f), 72);
        check("6 eSCO BR/fec32/hdr", int'({packet_BRmode_f, fec32encode_f, existpyheader_f}), 0);
        is_eSCO = 1'b0;
        latch(4'hD);
        check("D slots", int'(tx_slots_f), 3);
        check("D BR/DPSK/hdr", int'({packet_BRmode_f, packet_DPSK_f, existpyheader_f}), 3'b100);
        regi_payloadlen = 10'd1023; pktype_data = 1'b1;
        latch(4'h3);
        check("len wrap", int'(pylenbit_f), 0);
        latch(4'h0);
        check("0 pylenbit", int'(pylenbit_f), 0);
        is_BRmode = 1'b1; pktype_data = 1'b0; regi_payloadlen = 10'd50;

        // clamp on the MAX_SLOTS=3 instance
        latch(4'hE);
        check("E slots", int'(tx_slots_f), 5);
        check("E clamp slots", int'(u2_tx_slots_f), 3);
        b = strobe_n;
        u2_tx_at = -1;
        tx_q.push_back(b + 5);
        rx_q.push_back(RXT ? b + 6 : b + 10);
        slot(1'b1, 1'b0, 4'h0, 1);
        repeat (9) slot(1'b0, 1'b0, 4'h0, -1);
        check("E clamp endp strobe", u2_tx_at - b, 3);

        // restart mid-window, then reset mid-window
        latch(4'hF);
        slot(1'b1, 1'b0, 4'h0, 1);
        slot(1'b0, 1'b0, 4'h0, 1);
        slot(1'b1, 1'b0, 4'h0, 1);
        check("restart idx", int'(tx_slot_idx), 2);
        check("restart ext", int'(txextendslot), 1);
        repeat (2) slot(1'b0, 1'b0, 4'h0, 1);
        check("pre-rst idx", int'(tx_slot_idx), 4);
        rstz = 1'b0; #2;
        check("midrst flags", int'({txextendslot, rxextendslot, mask_corre_win, conns_rx1stslot}), 0);
        check("midrst idx", int'(tx_slot_idx), 1);
        check("midrst pylenbit", int'(pylenbit_f), 0);
        check("midrst slots", int'(tx_slots_f), 1);
        @(posedge clk_6M); #1;
        rstz = 1'b1;
        repeat (4) @(posedge clk_6M); #1;
        check("tx pending", tx_q.size(), 0);
        check("rx pending", rx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
